// File: rtl/alarm_bank.sv
// alarm_bank: bank of independent BCD alarm channels with ring / snooze / stop handling.
// Latency: ringing rises one cycle after the clock first matches an armed channel; hr/min readback is combinational.
// Backpressure: none; buttons and time inputs are level/pulse sampled every cycle.
// Ports: clk, rst (sync, active-high); clk_hr/clk_min current BCD time; min_tick minute pulse;
//        sel/addhr/addmin edit and read back one channel (hr/min); on per-channel arm;
//        snooze/stop global buttons; ringing per-channel flag; alarm_op OR of ringing.
module alarm_bank #(
    parameter int NUM_ALARMS     = 4,
    parameter int RING_MINUTES   = 5,
    parameter int SNOOZE_MINUTES = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            clk_hr,
    input  logic [7:0]            clk_min,
    input  logic                  min_tick,
    input  logic [2:0]            sel,
    input  logic                  addhr,
    input  logic                  addmin,
    input  logic [NUM_ALARMS-1:0] on,
    input  logic                  snooze,
    input  logic                  stop,
    output logic [7:0]            hr,
    output logic [7:0]            min,
    output logic [NUM_ALARMS-1:0] ringing,
    output logic                  alarm_op
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZED = 2'd2
    } state_t;

    localparam logic [3:0] RING_CNT   = 4'(RING_MINUTES);
    localparam logic [3:0] SNOOZE_CNT = 4'(SNOOZE_MINUTES);

    logic [7:0]            alm_hr  [NUM_ALARMS];
    logic [7:0]            alm_min [NUM_ALARMS];
    state_t                state_q [NUM_ALARMS];
    state_t                state_d [NUM_ALARMS];
    logic [3:0]            cnt_q   [NUM_ALARMS];
    logic [3:0]            cnt_d   [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] match;
    logic [NUM_ALARMS-1:0] match_d;

    // BCD hour increment with 23 -> 00 wrap.
    function automatic logic [7:0] hr_inc(input logic [7:0] h);
        logic [7:0] r;
        if (h == 8'h23)
            r = 8'h00;
        else if (h[3:0] == 4'd9)
            r = {h[7:4] + 4'd1, 4'd0};
        else
            r = {h[7:4], h[3:0] + 4'd1};
        return r;
    endfunction

    // BCD minute increment below 59; the 59 wrap is handled by the caller
    // because it also carries into the hour.
    function automatic logic [7:0] min_inc(input logic [7:0] m);
        logic [7:0] r;
        if (m[3:0] == 4'd9)
            r = {m[7:4] + 4'd1, 4'd0};
        else
            r = {m[7:4], m[3:0] + 4'd1};
        return r;
    endfunction

    // Alarm time edits; hour button wins when both are pressed.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                alm_hr[i]  <= 8'h00;
                alm_min[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                if (sel == 3'(i)) begin
                    if (addhr) begin
                        alm_hr[i] <= hr_inc(alm_hr[i]);
                    end else if (addmin) begin
                        if (alm_min[i] == 8'h59) begin
                            alm_min[i] <= 8'h00;
                            alm_hr[i]  <= hr_inc(alm_hr[i]);
                        end else begin
                            alm_min[i] <= min_inc(alm_min[i]);
                        end
                    end
                end
            end
        end
    end

    // Readback; out-of-range sel matches no channel and reads 00:00.
    always_comb begin
        hr  = 8'h00;
        min = 8'h00;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (sel == 3'(i)) begin
                hr  = alm_hr[i];
                min = alm_min[i];
            end
        end
    end

    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_ALARMS; i++)
            match[i] = (clk_hr == alm_hr[i]) && (clk_min == alm_min[i]);
    end

    // match_d resets high so a 00:00 clock at reset release is not an edge.
    always_ff @(posedge clk) begin
        if (rst) match_d <= '1;
        else     match_d <= match;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (rst) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= 4'd0;
            end else begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // FSM next state: on low > stop > snooze > countdown > match trigger
    always_comb begin
        for (int i = 0; i < NUM_ALARMS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (!on[i]) begin
                state_d[i] = IDLE;
                cnt_d[i]   = 4'd0;
            end else begin
                case (state_q[i])
                    IDLE: begin
                        if (match[i] && !match_d[i]) begin
                            state_d[i] = RINGING;
                            cnt_d[i]   = RING_CNT;
                        end
                    end
                    RINGING: begin
                        if (stop) begin
                            state_d[i] = IDLE;
                            cnt_d[i]   = 4'd0;
                        end else if (snooze) begin
                            state_d[i] = SNOOZED;
                            cnt_d[i]   = SNOOZE_CNT;
                        end else if (min_tick) begin
                            if (cnt_q[i] <= 4'd1) begin
                                state_d[i] = IDLE;
                                cnt_d[i]   = 4'd0;
                            end else begin
                                cnt_d[i] = cnt_q[i] - 4'd1;
                            end
                        end
                    end
                    SNOOZED: begin
                        if (stop) begin
                            state_d[i] = IDLE;
                            cnt_d[i]   = 4'd0;
                        end else if (min_tick) begin
                            if (cnt_q[i] <= 4'd1) begin
                                state_d[i] = RINGING;
                                cnt_d[i]   = RING_CNT;
                            end else begin
                                cnt_d[i] = cnt_q[i] - 4'd1;
                            end
                        end
                    end
                    default: begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = 4'd0;
                    end
                endcase
            end
        end
    end

    // FSM outputs: decoded straight from the state register
    always_comb begin
        ringing = '0;
        for (int i = 0; i < NUM_ALARMS; i++)
            ringing[i] = (state_q[i] == RINGING);
        alarm_op = |ringing;
    end

endmodule

// File: tb/tb_alarm_bank.sv
// tb_alarm_bank: directed vectors for alarm_bank with hand-computed expectations.
// Latency: inputs change 1 ns after a rising edge; outputs are checked 1 ns after the next edge.
// Backpressure: none.
module tb_alarm_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] clk_hr, clk_min;
    logic       min_tick;
    logic [2:0] sel;
    logic       addhr, addmin;
    logic [3:0] on;
    logic       snooze, stop;
    logic [7:0] hr, min;
    logic [3:0] ringing;
    logic       alarm_op;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    alarm_bank #(
        .NUM_ALARMS(4), .RING_MINUTES(5), .SNOOZE_MINUTES(9)
    ) dut (
        .clk(clk), .rst(rst), .clk_hr(clk_hr), .clk_min(clk_min),
        .min_tick(min_tick), .sel(sel), .addhr(addhr), .addmin(addmin),
        .on(on), .snooze(snooze), .stop(stop), .hr(hr), .min(min),
        .ringing(ringing), .alarm_op(alarm_op)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_hr(input int n);
        addhr = 1'b1; step(n); addhr = 1'b0;
    endtask

    task automatic press_min(input int n);
        addmin = 1'b1; step(n); addmin = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            min_tick = 1'b1; step(1); min_tick = 1'b0; step(1);
        end
    endtask

    // Bring the clock onto hh:mm from the preceding minute value.
    task automatic hit(input logic [7:0] h, input logic [7:0] m_before, input logic [7:0] m);
        clk_hr = h; clk_min = m_before; step(2);
        clk_min = m; step(1);
    endtask

    initial begin
        rst = 1'b1; clk_hr = 8'h00; clk_min = 8'h00; min_tick = 1'b0;
        sel = 3'd0; addhr = 1'b0; addmin = 1'b0; on = 4'b0000;
        snooze = 1'b0; stop = 1'b0;
        step(2);
        chk("rst_ringing", {4'd0, ringing}, 8'h00);
        chk("rst_alarm_op", {7'd0, alarm_op}, 8'h00);
        chk("rst_hr", hr, 8'h00);
        chk("rst_min", min, 8'h00);

        // Clock at 00:00 matches every channel at release but is not an edge.
        on = 4'b1111; rst = 1'b0; step(3);
        chk("release_no_trig", {4'd0, ringing}, 8'h00);
        on = 4'b0000; step(1);

        // Channel 1 to 07:30
        sel = 3'd1; press_hr(7); press_min(30);
        chk("ch1_hr", hr, 8'h07);
        chk("ch1_min", min, 8'h30);
        sel = 3'd0; #1;
        chk("ch0_untouched", {hr[7:0] | min[7:0]}, 8'h00);
        sel = 3'd5; #1;
        chk("sel_oob_hr", hr, 8'h00);
        sel = 3'd1;

        on = 4'b0010;
        clk_hr = 8'h07; clk_min = 8'h29; step(2);
        chk("pre_match", {4'd0, ringing}, 8'h00);
        clk_min = 8'h30; step(1);
        chk("ring_ch1", {4'd0, ringing}, 8'h02);
        chk("ring_op", {7'd0, alarm_op}, 8'h01);

        // Auto-stop after five ticks
        clk_min = 8'h34;
        tick(4);
        chk("ring_after4", {4'd0, ringing}, 8'h02);
        tick(1);
        chk("ring_after5", {4'd0, ringing}, 8'h00);
        step(5);
        chk("no_retrig_0734", {4'd0, ringing}, 8'h00);

        // Snooze, nine ticks back to ringing, then stop
        hit(8'h07, 8'h29, 8'h30);
        chk("ring_again", {4'd0, ringing}, 8'h02);
        snooze = 1'b1; step(1); snooze = 1'b0;
        chk("snoozed", {4'd0, ringing}, 8'h00);
        chk("snoozed_op", {7'd0, alarm_op}, 8'h00);
        tick(8);
        chk("snooze_after8", {4'd0, ringing}, 8'h00);
        tick(1);
        chk("snooze_after9", {4'd0, ringing}, 8'h02);
        stop = 1'b1; step(1); stop = 1'b0;
        chk("stopped", {4'd0, ringing}, 8'h00);
        chk("stopped_op", {7'd0, alarm_op}, 8'h00);
        step(3);
        chk("stop_no_retrig", {4'd0, ringing}, 8'h00);

        // BCD edit rules on channel 2
        sel = 3'd2;
        press_hr(10);
        chk("hr_09_to_10", hr, 8'h10);
        press_hr(13); press_min(59);
        chk("ch2_2359_hr", hr, 8'h23);
        chk("ch2_2359_min", min, 8'h59);
        press_min(1);
        chk("wrap_hr", hr, 8'h00);
        chk("wrap_min", min, 8'h00);
        press_hr(23); press_min(5); press_hr(1);
        chk("hr_23_to_00", hr, 8'h00);
        chk("hr_wrap_min", min, 8'h05);
        addhr = 1'b1; addmin = 1'b1; step(1); addhr = 1'b0; addmin = 1'b0;
        chk("both_hr", hr, 8'h01);
        chk("both_min", min, 8'h05);

        // Two channels at 06:00
        sel = 3'd0; press_hr(6);
        sel = 3'd3; press_hr(6);
        chk("ch3_hr", hr, 8'h06);
        on = 4'b1001;
        hit(8'h05, 8'h59, 8'h59);
        clk_hr = 8'h06; clk_min = 8'h00; step(1);
        chk("two_ring", {4'd0, ringing}, 8'h09);
        on = 4'b1000; step(1);
        chk("drop_on0", {4'd0, ringing}, 8'h08);
        stop = 1'b1; step(1); stop = 1'b0;
        chk("two_stop", {4'd0, ringing}, 8'h00);

        // Reset while channel 1 is snoozed
        on = 4'b0010; sel = 3'd1;
        hit(8'h07, 8'h29, 8'h30);
        chk("pre_rst_ring", {4'd0, ringing}, 8'h02);
        snooze = 1'b1; step(1); snooze = 1'b0;
        clk_hr = 8'h00; clk_min = 8'h00; rst = 1'b1; step(2);
        chk("rst_snz_ringing", {4'd0, ringing}, 8'h00);
        chk("rst_snz_hr", hr, 8'h00);
        rst = 1'b0; step(3);
        chk("rst_snz_op", {7'd0, alarm_op}, 8'h00);
        chk("rst_snz_min", min, 8'h00);
        tick(9);
        chk("rst_cleared_snooze", {4'd0, ringing}, 8'h00);
        clk_min = 8'h01; step(1);
        clk_min = 8'h00; step(1);
        chk("rematch_ring", {4'd0, ringing}, 8'h02);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
